ascon_fc_sequencer: RTL and testbench

Job-level controller that sits directly upstream of the fault-protected ASCON core wrapper and drives its full encrypt-then-decrypt round trip. It accepts one job (key, nonce, associated data, plaintext) over a valid/ready handshake and pulses encryption start. It captures the ciphertext, loops it back as the internal ciphertext and pulses decryption start. It then collects the authentication verdict and returns one response word per job, with timeout protection against a hung or faulted core.

---
 rtl/ascon_seq_pkg.sv | 18 +
 rtl/ascon_seq_timeout.sv | 26 ++
 rtl/ascon_fc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ascon_fc_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_seq_pkg.sv
// Shared widths and FSM encoding for the ASCON round-trip sequencer.
package ascon_seq_pkg;
  localparam int K_DEF   = 128;
  localparam int L_DEF   = 40;
  localparam int Y_DEF   = 40;
  localparam int NONCE_W = 128;
  localparam int TAG_W   = 128;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ENC_START = 3'd1;
  localparam logic [2:0] S_ENC_WAIT  = 3'd2;
  localparam logic [2:0] S_DEC_START = 3'd3;
  localparam logic [2:0] S_DEC_WAIT  = 3'd4;
  localparam logic [2:0] S_AUTH      = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;
endpackage

// File: rtl/ascon_seq_timeout.sv
// Wait-cycle counter: cleared before each wait, counts while enabled and
// saturates at TIMEOUT so expired stays asserted once reached.
module ascon_seq_timeout #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Clear has priority over counting; hold at LIMIT.
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != LIMIT))
      r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired = (r_cnt == LIMIT);
endmodule

// File: rtl/ascon_fc_sequencer.sv
// Job sequencer around the fault-protected ASCON core: encrypt, loop the
// ciphertext back, decrypt, then report tag, verdict and plaintext match.
// Counting the handshake cycle as cycle 0, resp_valid rises in cycle
// 4 + T_enc + T_dec, where T_enc/T_dec are the cycles spent in ENC_WAIT/DEC_WAIT.
module ascon_fc_sequencer
  import ascon_seq_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int L       = L_DEF,
  parameter int Y       = Y_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [K-1:0]       req_key,
  input  logic [NONCE_W-1:0] req_nonce,
  input  logic [L-1:0]       req_ad,
  input  logic [Y-1:0]       req_pt,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [Y-1:0]       resp_ct,
  output logic [TAG_W-1:0]   resp_tag,
  output logic               resp_auth_ok,
  output logic               resp_pt_match,
  output logic               resp_timeout,
  output logic [K-1:0]       fc_key,
  output logic [NONCE_W-1:0] fc_nonce,
  output logic [L-1:0]       fc_associated_data,
  output logic [Y-1:0]       fc_plain_text,
  output logic [Y-1:0]       fc_internal_cipher_text,
  output logic               fc_encryption_start,
  output logic               fc_decryption_start,
  input  logic [Y-1:0]       fc_cipher_text,
  input  logic [TAG_W-1:0]   fc_tag,
  input  logic [Y-1:0]       fc_dec_plain_text,
  input  logic               fc_encryption_ready,
  input  logic               fc_decryption_ready,
  input  logic               fc_message_authentication
);
  state_t             r_state;
  logic               r_enc_rdy_q, r_dec_rdy_q;
  logic [K-1:0]       r_key;
  logic [NONCE_W-1:0] r_nonce;
  logic [L-1:0]       r_ad;
  logic [Y-1:0]       r_pt, r_ct, r_dec_pt;
  logic [TAG_W-1:0]   r_tag;
  logic               r_enc_start, r_dec_start;
  logic               r_resp_valid, r_auth_ok, r_pt_match, r_timeout;
  logic               w_enc_edge, w_dec_edge, w_wait, w_clr, w_expired;

  // Only a fresh low->high transition counts; a level left high by the
  // previous job must not advance the FSM.
  assign w_enc_edge = fc_encryption_ready & ~r_enc_rdy_q;
  assign w_dec_edge = fc_decryption_ready & ~r_dec_rdy_q;
  assign w_wait     = (r_state == S_ENC_WAIT) || (r_state == S_DEC_WAIT);
  assign w_clr      = (r_state == S_ENC_START) || (r_state == S_DEC_START);

  ascon_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_en      (w_wait),
    .o_expired (w_expired)
  );

  // Job FSM with latched job data, captured results and start pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_enc_rdy_q  <= 1'b0;
      r_dec_rdy_q  <= 1'b0;
      r_key        <= '0;
      r_nonce      <= '0;
      r_ad         <= '0;
      r_pt         <= '0;
      r_ct         <= '0;
      r_tag        <= '0;
      r_dec_pt     <= '0;
      r_enc_start  <= 1'b0;
      r_dec_start  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_auth_ok    <= 1'b0;
      r_pt_match   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_enc_rdy_q <= fc_encryption_ready;
      r_dec_rdy_q <= fc_decryption_ready;
      r_enc_start <= 1'b0;
      r_dec_start <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_key       <= req_key;
          r_nonce     <= req_nonce;
          r_ad        <= req_ad;
          r_pt        <= req_pt;
          r_ct        <= '0;
          r_tag       <= '0;
          r_dec_pt    <= '0;
          r_auth_ok   <= 1'b0;
          r_pt_match  <= 1'b0;
          r_timeout   <= 1'b0;
          r_enc_start <= 1'b1;
          r_state     <= S_ENC_START;
        end
        S_ENC_START: r_state <= S_ENC_WAIT;
        S_ENC_WAIT: begin
          // An edge coinciding with expiry still wins.
          if (w_enc_edge) begin
            r_ct        <= fc_cipher_text;
            r_tag       <= fc_tag;
            r_dec_start <= 1'b1;
            r_state     <= S_DEC_START;
          end else if (w_expired) begin
            r_timeout    <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_DEC_START: r_state <= S_DEC_WAIT;
        S_DEC_WAIT: begin
          if (w_dec_edge) begin
            r_dec_pt <= fc_dec_plain_text;
            r_state  <= S_AUTH;
          end else if (w_expired) begin
            // Aborted jobs report nothing but the timeout flag.
            r_ct         <= '0;
            r_tag        <= '0;
            r_timeout    <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_AUTH: begin
          // Core's verdict is registered one clock after the ready edge.
          r_auth_ok    <= fc_message_authentication;
          r_pt_match   <= (r_dec_pt == r_pt);
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: if (resp_ready) begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready               = (r_state == S_IDLE);
  assign resp_valid              = r_resp_valid;
  assign resp_ct                 = r_ct;
  assign resp_tag                = r_tag;
  assign resp_auth_ok            = r_auth_ok;
  assign resp_pt_match           = r_pt_match;
  assign resp_timeout            = r_timeout;
  assign fc_key                  = r_key;
  assign fc_nonce                = r_nonce;
  assign fc_associated_data      = r_ad;
  assign fc_plain_text           = r_pt;
  assign fc_internal_cipher_text = r_ct;
  assign fc_encryption_start     = r_enc_start;
  assign fc_decryption_start     = r_dec_start;
endmodule

// File: tb/tb_ascon_fc_sequencer.sv
// Directed bench for ascon_fc_sequencer against a behavioural core stub.
// Stub cipher: ct = pt ^ key[39:0] ^ MASK, tag = key ^ {nonce[127:40], ad};
// decryption inverts it, verdict is registered one clock after dec ready.
// Latency below is counted in clock edges from the accepting edge.
module tb_ascon_fc_sequencer;
  localparam int K  = 128;
  localparam int L  = 40;
  localparam int Y  = 40;
  localparam int TO = 16;
  localparam logic [Y-1:0]   MASK = 40'h5A5A5A5A5A;
  localparam logic [K-1:0]   KEY0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [K-1:0]   KEY1 = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  logic [K-1:0] req_key;
  logic [127:0] req_nonce;
  logic [L-1:0] req_ad;
  logic [Y-1:0] req_pt;
  logic resp_valid, resp_ready;
  logic [Y-1:0] resp_ct;
  logic [127:0] resp_tag;
  logic resp_auth_ok, resp_pt_match, resp_timeout;
  logic [K-1:0] fc_key;
  logic [127:0] fc_nonce;
  logic [L-1:0] fc_associated_data;
  logic [Y-1:0] fc_plain_text, fc_internal_cipher_text;
  logic fc_encryption_start, fc_decryption_start;
  logic [Y-1:0] fc_cipher_text, fc_dec_plain_text;
  logic [127:0] fc_tag;
  logic fc_encryption_ready, fc_decryption_ready, fc_message_authentication;

  always #5 clk = ~clk;

  ascon_fc_sequencer #(.K(K), .L(L), .Y(Y), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_nonce(req_nonce), .req_ad(req_ad), .req_pt(req_pt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ct(resp_ct),
    .resp_tag(resp_tag), .resp_auth_ok(resp_auth_ok),
    .resp_pt_match(resp_pt_match), .resp_timeout(resp_timeout),
    .fc_key(fc_key), .fc_nonce(fc_nonce),
    .fc_associated_data(fc_associated_data), .fc_plain_text(fc_plain_text),
    .fc_internal_cipher_text(fc_internal_cipher_text),
    .fc_encryption_start(fc_encryption_start),
    .fc_decryption_start(fc_decryption_start),
    .fc_cipher_text(fc_cipher_text), .fc_tag(fc_tag),
    .fc_dec_plain_text(fc_dec_plain_text),
    .fc_encryption_ready(fc_encryption_ready),
    .fc_decryption_ready(fc_decryption_ready),
    .fc_message_authentication(fc_message_authentication)
  );

  function automatic logic [Y-1:0] f_ct(input logic [K-1:0] k, input logic [Y-1:0] p);
    return p ^ k[Y-1:0] ^ MASK;
  endfunction
  function automatic logic [127:0] f_tag(input logic [K-1:0] k, input logic [127:0] n,
                                         input logic [L-1:0] a);
    return k ^ {n[127:L], a};
  endfunction

  // ---------------- core stub ----------------
  // On a start pulse the ready stays (stale) high for cfg_d* cycles, drops,
  // then rises cfg_l* cycles later with the new result; hang never rises.
  bit cfg_hang_e, cfg_hang_d, cfg_fault;
  int cfg_de, cfg_le, cfg_dd, cfg_ld;
  int e_cnt, d_cnt;

  always @(posedge clk) begin
    if (rst) begin
      e_cnt <= 0; d_cnt <= 0;
      fc_encryption_ready <= 1'b0; fc_decryption_ready <= 1'b0;
      fc_cipher_text <= '0; fc_tag <= '0; fc_dec_plain_text <= '0;
      fc_message_authentication <= 1'b0;
    end else begin
      fc_message_authentication <= fc_decryption_ready && !cfg_fault &&
                                   (fc_internal_cipher_text == fc_cipher_text);
      if (fc_encryption_start) e_cnt <= cfg_de + cfg_le;
      else if (e_cnt > 0) e_cnt <= e_cnt - 1;
      if (fc_encryption_start && cfg_de == 0) fc_encryption_ready <= 1'b0;
      else if (!fc_encryption_start && e_cnt == cfg_le + 1) fc_encryption_ready <= 1'b0;
      else if (!fc_encryption_start && e_cnt == 1 && !cfg_hang_e) begin
        fc_encryption_ready <= 1'b1;
        fc_cipher_text <= f_ct(fc_key, fc_plain_text);
        fc_tag <= f_tag(fc_key, fc_nonce, fc_associated_data);
      end
      if (fc_decryption_start) d_cnt <= cfg_dd + cfg_ld;
      else if (d_cnt > 0) d_cnt <= d_cnt - 1;
      if (fc_decryption_start && cfg_dd == 0) fc_decryption_ready <= 1'b0;
      else if (!fc_decryption_start && d_cnt == cfg_ld + 1) fc_decryption_ready <= 1'b0;
      else if (!fc_decryption_start && d_cnt == 1 && !cfg_hang_d) begin
        fc_decryption_ready <= 1'b1;
        fc_dec_plain_text <= cfg_fault ? '0 : (fc_internal_cipher_text ^ fc_key[Y-1:0] ^ MASK);
      end
    end
  end

  // ---------------- start-pulse monitor ----------------
  int n_enc = 0, n_dec = 0, n_overlap = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (fc_encryption_start) n_enc++;
      if (fc_decryption_start) n_dec++;
      if (fc_encryption_start && fc_decryption_start) n_overlap++;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_fc_key"}, fc_key, '0);
    chk({nm, "_fc_nonce"}, fc_nonce, '0);
    chk({nm, "_fc_data"}, {fc_associated_data, fc_plain_text, fc_internal_cipher_text}, '0);
    chk({nm, "_resp_tag"}, resp_tag, '0);
    chk({nm, "_ctl"}, {resp_ct, fc_encryption_start, fc_decryption_start, resp_valid,
                       resp_auth_ok, resp_pt_match, resp_timeout, req_ready},
        {40'h0, 7'b0000001});
  endtask

  typedef struct {
    logic [K-1:0] key; logic [127:0] nonce; logic [L-1:0] ad; logic [Y-1:0] pt;
    bit hang_e, hang_d, fault;
    int de, le, dd, ld, bp; bit rr_early;
    bit exp_to, exp_auth, exp_match; int exp_lat, exp_dec_pulses;
  } vec_t;

  function automatic vec_t mk(input logic [K-1:0] k, input logic [127:0] n,
      input logic [L-1:0] a, input logic [Y-1:0] p, input bit he, input bit hd,
      input bit f, input int de, input int le, input int dd, input int ld,
      input int bp, input bit rre, input bit eto, input bit eau, input bit ema,
      input int elat, input int edp);
    vec_t v;
    v.key = k; v.nonce = n; v.ad = a; v.pt = p;
    v.hang_e = he; v.hang_d = hd; v.fault = f;
    v.de = de; v.le = le; v.dd = dd; v.ld = ld; v.bp = bp; v.rr_early = rre;
    v.exp_to = eto; v.exp_auth = eau; v.exp_match = ema;
    v.exp_lat = elat; v.exp_dec_pulses = edp;
    return v;
  endfunction

  task automatic run_job(input vec_t v, input string nm);
    int n, lat, e0, d0;
    logic [Y-1:0] ect, s_ct;
    logic [127:0] etag, s_tag;
    logic [2:0] s_fl;
    bit ok;
    cfg_hang_e = v.hang_e; cfg_hang_d = v.hang_d; cfg_fault = v.fault;
    cfg_de = v.de; cfg_le = v.le; cfg_dd = v.dd; cfg_ld = v.ld;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_req_ready"}, req_ready, 1);
    req_key = v.key; req_nonce = v.nonce; req_ad = v.ad; req_pt = v.pt;
    req_valid = 1'b1;
    e0 = n_enc; d0 = n_dec;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.rr_early) resp_ready = 1'b1;
    lat = 0;
    while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
    ect  = v.exp_to ? '0 : f_ct(v.key, v.pt);
    etag = v.exp_to ? '0 : f_tag(v.key, v.nonce, v.ad);
    chk({nm, "_latency"}, lat, v.exp_lat);
    chk({nm, "_timeout"}, resp_timeout, v.exp_to);
    chk({nm, "_ct"}, resp_ct, ect);
    chk({nm, "_tag"}, resp_tag, etag);
    chk({nm, "_auth_ok"}, resp_auth_ok, v.exp_auth);
    chk({nm, "_pt_match"}, resp_pt_match, v.exp_match);
    chk({nm, "_enc_pulses"}, n_enc - e0, 1);
    chk({nm, "_dec_pulses"}, n_dec - d0, v.exp_dec_pulses);
    if (v.bp > 0) begin
      s_ct = resp_ct; s_tag = resp_tag;
      s_fl = {resp_auth_ok, resp_pt_match, resp_timeout};
      ok = 1'b1;
      repeat (v.bp) begin
        @(negedge clk);
        if (!resp_valid || req_ready || resp_ct !== s_ct || resp_tag !== s_tag ||
            {resp_auth_ok, resp_pt_match, resp_timeout} !== s_fl) ok = 1'b0;
      end
      chk({nm, "_bp_stable"}, ok, 1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, "_resp_done"}, {resp_valid, req_ready}, 2'b01);
  endtask

  vec_t vecs[8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // key, nonce, ad, pt, hang_e, hang_d, fault, de, le, dd, ld, bp, rr_early,
    // exp_to, exp_auth, exp_match, exp_lat, exp_dec_pulses
    vecs[0] = mk(KEY0, KEY0, 40'h0001020304, 40'h0001020304, 0,0,0, 0,3,0,2, 0,0, 0,1,1, 10,1);
    vecs[1] = mk(KEY1, ~KEY0, 40'h99887766AA, 40'h1122334455, 0,0,0, 3,2,2,3, 0,0, 0,1,1, 15,1);
    vecs[2] = mk(KEY0, KEY1, 40'h0102030405, 40'h5555555555, 1,0,0, 0,4,0,2, 0,0, 1,0,0, 18,0);
    vecs[3] = mk(KEY1, KEY1, 40'hFFEEDDCCBB, 40'h123456789A, 0,0,1, 0,2,0,2, 0,1, 0,0,0, 9,1);
    vecs[4] = mk(KEY0, KEY1, 40'h0A0B0C0D0E, 40'h0F0F0F0F0F, 0,0,0, 0,16,0,1, 0,0, 0,1,1, 22,1);
    vecs[5] = mk(KEY1, KEY0, 40'h1111111111, 40'h2222222222, 0,0,0, 0,17,0,1, 0,0, 1,0,0, 18,0);
    vecs[6] = mk(KEY0, KEY0, 40'h3333333333, 40'h4444444444, 0,1,0, 0,2,0,2, 0,0, 1,0,0, 22,1);
    vecs[7] = mk(KEY1, ~KEY1, 40'hC0FFEE0001, 40'h7766554433, 0,0,0, 0,1,0,1, 10,0, 0,1,1, 7,1);

    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_key = '0; req_nonce = '0; req_ad = '0; req_pt = '0;
    cfg_hang_e = 0; cfg_hang_d = 0; cfg_fault = 0;
    cfg_de = 0; cfg_le = 1; cfg_dd = 0; cfg_ld = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready, 1);

    for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // Reset during DEC_WAIT, then a clean job.
    cfg_hang_e = 0; cfg_hang_d = 0; cfg_fault = 0;
    cfg_de = 0; cfg_le = 2; cfg_dd = 0; cfg_ld = 8;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_key = KEY1; req_nonce = KEY0; req_ad = 40'h0102030405; req_pt = 40'h0F0E0D0C0B;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!fc_decryption_start && n < 100) begin @(negedge clk); n++; end
    chk("rst_mid_reach_dec", fc_decryption_start, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_rst("rst_mid");
    rst = 1'b0;
    run_job(mk(KEY0, KEY1, 40'h5566778899, 40'hAABBCCDDEE, 0,0,0, 0,2,0,2, 0,0, 0,1,1, 9,1),
            "post_rst");

    chk("start_overlap", n_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
